mem_copy_master: RTL and testbench

- picorv32-native-bus initiator (DMA copy engine) that drives the same valid/ready bus the CPU uses toward the memory controller.
- On `start`, copies `word_count` 32-bit words from `src_addr` to `dst_addr`. Each word is one read transaction followed by one full-word write transaction.
- Sits beside the CPU behind the bus arbiter/mux, as a second bus master.

---
 rtl/mem_copy_master.sv | 173 +++++++++++++++++
 tb/tb_mem_copy_master.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_master.sv
// DMA copy engine acting as a second master on the picorv32 native valid/ready bus.
// Copies word_count words from src_addr to dst_addr, one read then one write per word.
module mem_copy_master #(
  parameter int unsigned COUNT_W = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [31:0]        src_addr,
  input  logic [31:0]        dst_addr,
  input  logic [COUNT_W-1:0] word_count,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               mem_valid,
  output logic               mem_instr,
  output logic [3:0]         mem_wstrb,
  output logic [31:0]        mem_wdata,
  output logic [31:0]        mem_addr,
  input  logic               mem_ready,
  input  logic [31:0]        mem_rdata
);

  localparam bit          TimeoutEn   = (TIMEOUT != 0);
  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT) - 32'd1;

  typedef enum logic [2:0] {StIdle, StRd, StRdGap, StWr, StWrGap, StFin} state_e;

  state_e             state_q, state_d;
  logic [31:0]        src_q, src_d;
  logic [31:0]        dst_q, dst_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]        data_q, data_d;
  logic               error_q, error_d;
  logic               valid_q, valid_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        wait_q, wait_d;
  logic               timeout_hit;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{src_addr[1:0], dst_addr[1:0]};

  // Fires on the last permitted wait cycle so valid is high for exactly TIMEOUT stalled cycles.
  assign timeout_hit = TimeoutEn && valid_q && !mem_ready && (wait_q == TimeoutLast);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    error_d = error_q;
    valid_d = valid_q;
    wstrb_d = wstrb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wait_d  = wait_q;
    if (valid_q && !mem_ready) begin
      wait_d = wait_q + 32'd1;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          src_d   = {src_addr[31:2], 2'b00};
          dst_d   = {dst_addr[31:2], 2'b00};
          cnt_d   = word_count;
          error_d = 1'b0;
          if (word_count == '0) begin
            state_d = StFin;
          end else begin
            state_d = StRd;
            valid_d = 1'b1;
            wstrb_d = 4'b0000;
            addr_d  = {src_addr[31:2], 2'b00};
            wait_d  = 32'd0;
          end
        end
      end
      StRd: begin
        if (mem_ready) begin
          data_d  = mem_rdata;
          valid_d = 1'b0;
          state_d = StRdGap;
        end else if (timeout_hit) begin
          valid_d = 1'b0;
          error_d = 1'b1;
          state_d = StFin;
        end
      end
      StRdGap: begin
        state_d = StWr;
        valid_d = 1'b1;
        wstrb_d = 4'b1111;
        addr_d  = dst_q;
        wdata_d = data_q;
        wait_d  = 32'd0;
      end
      StWr: begin
        if (mem_ready) begin
          src_d   = src_q + 32'd4;
          dst_d   = dst_q + 32'd4;
          cnt_d   = cnt_q - 1'b1;
          valid_d = 1'b0;
          state_d = StWrGap;
        end else if (timeout_hit) begin
          valid_d = 1'b0;
          error_d = 1'b1;
          state_d = StFin;
        end
      end
      StWrGap: begin
        if (cnt_q == '0) begin
          state_d = StFin;
        end else begin
          state_d = StRd;
          valid_d = 1'b1;
          wstrb_d = 4'b0000;
          addr_d  = src_q;
          wait_d  = 32'd0;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      error_q <= 1'b0;
      valid_q <= 1'b0;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      error_q <= error_d;
      valid_q <= valid_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wait_q  <= wait_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFin);
  assign error     = error_q;
  assign mem_valid = valid_q;
  assign mem_instr = 1'b0;
  assign mem_wstrb = wstrb_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_copy_master.sv
// Bench for mem_copy_master: delay-programmable bus responder, scoreboard of expected
// bus transactions and done pulses, and a negedge monitor that pops and compares.
module tb_mem_copy_master;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] word_count;
  logic        busy, done, error;
  logic        mem_valid, mem_instr, mem_ready;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata, mem_addr, mem_rdata;

  mem_copy_master #(
    .COUNT_W(16),
    .TIMEOUT(8)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .word_count(word_count),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  txn_t        exp_q[$];
  logic        exp_done[$];
  logic [31:0] mem[logic [31:0]];
  int          fixed_delay = 1;
  bit          rand_delay = 1'b0;

  // Responder state
  int          rsp_wait = -1;
  int          rsp_delay = 0;
  logic [31:0] rsp_addr, rsp_wdata;
  logic        rsp_we;

  // Monitor state
  logic        mon_hs = 1'b0, mon_v = 1'b0;
  logic [31:0] mon_addr, mon_wdata;
  logic [3:0]  mon_wstrb;
  txn_t        mon_t;
  logic        mon_e;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic push_txn(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    txn_t t;
    t.addr = a;
    t.wstrb = s;
    t.wdata = d;
    exp_q.push_back(t);
  endtask

  task automatic expect_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      push_txn((s & ~32'd3) + 32'(i * 4), 4'h0, 32'd0);
      push_txn((d & ~32'd3) + 32'(i * 4), 4'hF, rd((s & ~32'd3) + 32'(i * 4)));
    end
  endtask

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    word_count = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  // Responder: raises ready after a programmable number of wait cycles, commits writes.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn) begin
        mem_ready = 1'b0;
        rsp_wait = -1;
      end else if (mem_ready) begin
        if (rsp_we) mem[rsp_addr] = rsp_wdata;
        mem_ready = 1'b0;
        rsp_wait = -1;
      end else if (mem_valid) begin
        if (rsp_wait < 0) begin
          rsp_wait = 0;
          rsp_delay = rand_delay ? int'($urandom_range(5, 0)) : fixed_delay;
        end
        if (rsp_wait >= rsp_delay) begin
          mem_ready = 1'b1;
          mem_rdata = rd(mem_addr);
          rsp_addr = mem_addr;
          rsp_we = (mem_wstrb == 4'hF);
          rsp_wdata = mem_wdata;
        end else begin
          rsp_wait++;
        end
      end else begin
        rsp_wait = -1;
      end
    end
  end

  // Monitor: compares every handshake and done pulse against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!resetn) begin
        mon_hs = 1'b0;
        mon_v = 1'b0;
      end else begin
        if (mon_hs) chk("idle_gap_after_txn", 32'(mem_valid), 32'd0);
        if (mon_v && !mon_hs && mem_valid) begin
          chk("addr_stable", mem_addr, mon_addr);
          chk("wstrb_stable", 32'(mem_wstrb), 32'(mon_wstrb));
          chk("wdata_stable", mem_wdata, mon_wdata);
        end
        if (mem_valid && mem_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_txn: got addr %08h expected no transaction", mem_addr);
          end else begin
            mon_t = exp_q.pop_front();
            chk("txn_addr", mem_addr, mon_t.addr);
            chk("txn_wstrb", 32'(mem_wstrb), 32'(mon_t.wstrb));
            chk("txn_instr", 32'(mem_instr), 32'd0);
            if (mon_t.wstrb == 4'hF) chk("txn_wdata", mem_wdata, mon_t.wdata);
          end
        end
        if (done) begin
          if (exp_done.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done=1 expected done=0");
          end else begin
            mon_e = exp_done.pop_front();
            chk("done_error", 32'(error), 32'(mon_e));
          end
        end
        mon_hs = mem_valid && mem_ready;
        mon_v = mem_valid;
        mon_addr = mem_addr;
        mon_wstrb = mem_wstrb;
        mon_wdata = mem_wdata;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int n;
    bit found;
    resetn = 1'b0;
    start = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    word_count = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    resetn = 1'b1;

    // 4-word copy, ready one cycle after valid
    fixed_delay = 1;
    push_txn(32'h100, 4'h0, 32'h0);  push_txn(32'h200, 4'hF, 32'h0100FEFF);
    push_txn(32'h104, 4'h0, 32'h0);  push_txn(32'h204, 4'hF, 32'h0104FEFB);
    push_txn(32'h108, 4'h0, 32'h0);  push_txn(32'h208, 4'hF, 32'h0108FEF7);
    push_txn(32'h10C, 4'h0, 32'h0);  push_txn(32'h20C, 4'hF, 32'h010CFEF3);
    exp_done.push_back(1'b0);
    pulse_start(32'h100, 32'h200, 16'd4);
    chk("copy4_busy", 32'(busy), 32'd1);
    wait_done("copy4_done");
    // start presented during the done cycle must be ignored
    src_addr = 32'h900;
    word_count = 16'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_fin_busy", 32'(busy), 32'd0);
    chk("start_in_fin_valid", 32'(mem_valid), 32'd0);
    chk("copy4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Zero-length copy: no bus activity, done in the cycle after acceptance
    exp_done.push_back(1'b0);
    pulse_start(32'h100, 32'h200, 16'd0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd1);
    chk("zero_valid", 32'(mem_valid), 32'd0);
    @(negedge clk);
    chk("zero_done_after", 32'(done), 32'd0);
    chk("zero_busy_after", 32'(busy), 32'd0);
    chk("zero_valid_after", 32'(mem_valid), 32'd0);

    // Misaligned addresses and destination wrap
    fixed_delay = 0;
    push_txn(32'h00000100, 4'h0, 32'h0);  push_txn(32'hFFFFFFFC, 4'hF, 32'h0100FEFF);
    push_txn(32'h00000104, 4'h0, 32'h0);  push_txn(32'h00000000, 4'hF, 32'h0104FEFB);
    exp_done.push_back(1'b0);
    pulse_start(32'h103, 32'hFFFFFFFE, 16'd2);
    wait_done("wrap_done");
    chk("wrap_sb_empty", 32'(exp_q.size()), 32'd0);

    // Responder never answers: abort after 8 stalled cycles
    fixed_delay = 100000;
    exp_done.push_back(1'b1);
    pulse_start(32'h300, 32'h400, 16'd3);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (done) break;
      if (mem_valid) n++;
      @(negedge clk);
    end
    chk("timeout_valid_cycles", 32'(n), 32'd8);
    chk("timeout_done", 32'(done), 32'd1);
    chk("timeout_error", 32'(error), 32'd1);
    @(negedge clk);
    chk("timeout_error_sticky", 32'(error), 32'd1);
    chk("timeout_busy_after", 32'(busy), 32'd0);
    fixed_delay = 0;
    expect_copy(32'h180, 32'h280, 1);
    exp_done.push_back(1'b0);
    pulse_start(32'h180, 32'h280, 16'd1);
    chk("error_cleared", 32'(error), 32'd0);
    wait_done("after_timeout_done");

    // Reset asserted while a write is on the bus
    fixed_delay = 3;
    expect_copy(32'h700, 32'h800, 2);
    exp_done.push_back(1'b0);
    pulse_start(32'h700, 32'h800, 16'd2);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (mem_valid && mem_wstrb == 4'hF) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("reset_found_write", 32'(found), 32'd1);
    #1 resetn = 1'b0;
    #1;
    chk("reset_mid_valid", 32'(mem_valid), 32'd0);
    chk("reset_mid_busy", 32'(busy), 32'd0);
    chk("reset_mid_done", 32'(done), 32'd0);
    chk("reset_mid_addr", mem_addr, 32'd0);
    exp_q.delete();
    exp_done.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("reset_idle_busy", 32'(busy), 32'd0);
    fixed_delay = 0;
    expect_copy(32'h140, 32'h240, 1);
    exp_done.push_back(1'b0);
    pulse_start(32'h140, 32'h240, 16'd1);
    wait_done("reset_recover_done");
    chk("reset_recover_mem", mem[32'h240], 32'h0140FEBF);

    // Random ready delays with start re-pulsed while busy
    rand_delay = 1'b1;
    expect_copy(32'h500, 32'h600, 8);
    exp_done.push_back(1'b0);
    pulse_start(32'h500, 32'h600, 16'd8);
    for (int k = 0; k < 3; k++) begin
      repeat (4) @(negedge clk);
      src_addr = 32'h900;
      dst_addr = 32'hA00;
      word_count = 16'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done("rand_done");
    @(negedge clk);
    chk("rand_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("rand_done_q_empty", 32'(exp_done.size()), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("rand_dst_mem", mem[32'h600 + 32'(i * 4)], rd(32'h500 + 32'(i * 4)));
    end
    chk("restart_no_write", 32'(mem.exists(32'hA00)), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
